// File: rtl/clkout_divider_bank_if.sv
// DRP-style register access bus for clkout_divider_bank.
// The master drives address/data/strobes; the slave returns read data and the acknowledge.
interface clkout_divider_bank_if;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic        DEN;
  logic        DWE;
  logic [15:0] DO;
  logic        DRDY;

  modport master (output DADDR, DI, DEN, DWE, input DO, DRDY);
  modport slave  (input DADDR, DI, DEN, DWE, output DO, DRDY);
endinterface

// File: rtl/clkout_divider_bank.sv
// Divided-clock output bank for the PLL/MMCM models: CHANNELS clocks derived from CLKIN,
// each with programmable high/low/phase, restarted phase-aligned by a lock sequencer.
module clkout_divider_bank #(
  parameter int unsigned CHANNELS     = 7,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned LOCK_CYCLES  = 64,
  parameter int unsigned DEFAULT_HIGH = 1,
  parameter int unsigned DEFAULT_LOW  = 1
) (
  input  logic                CLKIN,
  input  logic                RSTN,
  input  logic                PWRDWN,
  clkout_divider_bank_if.slave drp,
  output logic [CHANNELS-1:0] CLKOUT,
  output logic [CHANNELS-1:0] CLKOUTB,
  output logic                LOCKED
);

  localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef logic [CNT_WIDTH-1:0] fld_t;
  typedef logic [CNT_WIDTH:0]   cnt_t;
  typedef logic [LCW-1:0]       lcnt_t;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_LOCKING = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam lcnt_t LOCK_LOAD = lcnt_t'(LOCK_CYCLES - 1);

  state_t state_q, state_d;
  lcnt_t  lock_cnt_q, lock_cnt_d;

  logic        pend_q, pend_d;
  logic        pend_we_q, pend_we_d;
  logic [6:0]  pend_addr_q, pend_addr_d;
  logic [15:0] pend_di_q, pend_di_d;
  logic [15:0] do_q, do_d;
  logic        drdy_q, drdy_d;
  logic [15:0] rdata;
  logic        wr_commit;

  logic [CHANNELS-1:0][CNT_WIDTH-1:0] high_q, high_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] low_q, low_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] phase_q, phase_d;
  logic [CHANNELS-1:0]                en_q, en_d;

  logic [CHANNELS-1:0][CNT_WIDTH:0]   ch_cnt_q, ch_cnt_d;
  logic [CHANNELS-1:0]                started_q, started_d;
  logic [CHANNELS-1:0]                clk_q, clk_d;

  logic run_next;
  logic enter_run;

  function automatic logic [7:0] pad8(input fld_t v);
    logic [7:0] r;
    r = '0;
    r[CNT_WIDTH-1:0] = v;
    return r;
  endfunction

  // A zero field encodes 2**CNT_WIDTH; returns the span minus one as a reload value.
  function automatic cnt_t span_m1(input fld_t v);
    cnt_t e;
    e = {(v == '0), v};
    return e - cnt_t'(1);
  endfunction

  // DRP: capture the access at edge t, commit and acknowledge at edge t+1.
  always_comb begin
    pend_d      = drp.DEN;
    pend_we_d   = drp.DWE;
    pend_addr_d = drp.DADDR;
    pend_di_d   = drp.DI;
    high_d      = high_q;
    low_d       = low_q;
    phase_d     = phase_q;
    en_d        = en_q;
    rdata       = '0;
    wr_commit   = pend_q && pend_we_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (pend_addr_q == 7'(2 * c)) begin
        rdata = {pad8(high_q[c]), pad8(low_q[c])};
        if (wr_commit) begin
          high_d[c] = pend_di_q[8 +: CNT_WIDTH];
          low_d[c]  = pend_di_q[0 +: CNT_WIDTH];
        end
      end
      if (pend_addr_q == 7'(2 * c + 1)) begin
        rdata = {7'b0, en_q[c], pad8(phase_q[c])};
        if (wr_commit) begin
          phase_d[c] = pend_di_q[0 +: CNT_WIDTH];
          en_d[c]    = pend_di_q[8];
        end
      end
    end
    drdy_d = pend_q;
    do_d   = pend_q ? rdata : '0;
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_OFF: begin
        if (!PWRDWN) begin
          state_d    = ST_LOCKING;
          lock_cnt_d = LOCK_LOAD;
        end
      end
      ST_LOCKING: begin
        if (wr_commit) begin
          lock_cnt_d = LOCK_LOAD;
        end else if (lock_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          lock_cnt_d = lock_cnt_q - lcnt_t'(1);
        end
      end
      ST_RUN: begin
        if (wr_commit) begin
          state_d    = ST_LOCKING;
          lock_cnt_d = LOCK_LOAD;
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (PWRDWN) begin
      state_d = ST_OFF;
    end
  end

  assign run_next  = (state_d == ST_RUN);
  assign enter_run = run_next && (state_q != ST_RUN);

  // started_q=0 means the channel is still waiting out its phase offset.
  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    started_d = started_q;
    clk_d     = clk_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (!run_next || !en_q[c]) begin
        clk_d[c]     = 1'b0;
        started_d[c] = 1'b0;
        ch_cnt_d[c]  = '0;
      end else if (enter_run) begin
        if (phase_q[c] == '0) begin
          clk_d[c]     = 1'b1;
          started_d[c] = 1'b1;
          ch_cnt_d[c]  = span_m1(high_q[c]);
        end else begin
          clk_d[c]     = 1'b0;
          started_d[c] = 1'b0;
          ch_cnt_d[c]  = {1'b0, phase_q[c]} - cnt_t'(1);
        end
      end else if (ch_cnt_q[c] == '0) begin
        if (!started_q[c] || !clk_q[c]) begin
          clk_d[c]     = 1'b1;
          started_d[c] = 1'b1;
          ch_cnt_d[c]  = span_m1(high_q[c]);
        end else begin
          clk_d[c]    = 1'b0;
          ch_cnt_d[c] = span_m1(low_q[c]);
        end
      end else begin
        ch_cnt_d[c] = ch_cnt_q[c] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge CLKIN or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_OFF;
      lock_cnt_q  <= '0;
      pend_q      <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_di_q   <= '0;
      do_q        <= '0;
      drdy_q      <= 1'b0;
      high_q      <= {CHANNELS{fld_t'(DEFAULT_HIGH)}};
      low_q       <= {CHANNELS{fld_t'(DEFAULT_LOW)}};
      phase_q     <= '0;
      en_q        <= '1;
      ch_cnt_q    <= '0;
      started_q   <= '0;
      clk_q       <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      pend_q      <= pend_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_di_q   <= pend_di_d;
      do_q        <= do_d;
      drdy_q      <= drdy_d;
      high_q      <= high_d;
      low_q       <= low_d;
      phase_q     <= phase_d;
      en_q        <= en_d;
      ch_cnt_q    <= ch_cnt_d;
      started_q   <= started_d;
      clk_q       <= clk_d;
    end
  end

  assign LOCKED   = (state_q == ST_RUN);
  assign CLKOUT   = clk_q;
  assign CLKOUTB  = LOCKED ? ~clk_q : '0;
  assign drp.DO   = do_q;
  assign drp.DRDY = drdy_q;

endmodule

// File: tb/tb_clkout_divider_bank.sv
// Directed bench for clkout_divider_bank: lock timing, DRP access, channel waveforms,
// power-down and asynchronous reset, checked against hand-computed values.
module tb_clkout_divider_bank;
  localparam int unsigned CH = 7;
  localparam int unsigned LC = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          pwrdwn;
  logic [CH-1:0] clkout;
  logic [CH-1:0] clkoutb;
  logic          locked;
  int            tests = 0;
  int            fails = 0;

  clkout_divider_bank_if bus ();

  clkout_divider_bank #(
    .CHANNELS    (CH),
    .CNT_WIDTH   (8),
    .LOCK_CYCLES (LC),
    .DEFAULT_HIGH(1),
    .DEFAULT_LOW (1)
  ) dut (
    .CLKIN  (clk),
    .RSTN   (rstn),
    .PWRDWN (pwrdwn),
    .drp    (bus),
    .CLKOUT (clkout),
    .CLKOUTB(clkoutb),
    .LOCKED (locked)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One DRP access; returns DO/DRDY/LOCKED in the acknowledge cycle and DRDY one cycle later.
  task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d,
                     output logic [15:0] rdo, output logic rdy, output logic lk, output logic rdy2);
    bus.DEN   = 1'b1;
    bus.DWE   = we;
    bus.DADDR = a;
    bus.DI    = d;
    tick;
    bus.DEN = 1'b0;
    bus.DWE = 1'b0;
    tick;
    rdo = bus.DO;
    rdy = bus.DRDY;
    lk  = locked;
    tick;
    rdy2 = bus.DRDY;
  endtask

  task automatic wait_lock(output int n);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      tick;
      if (locked) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] rdo;
    logic        rdy, lk, rdy2, bad;
    logic [9:0]  pat, expv;
    int          n, hi, lo;

    rstn      = 1'b0;
    pwrdwn    = 1'b0;
    bus.DEN   = 1'b0;
    bus.DWE   = 1'b0;
    bus.DADDR = '0;
    bus.DI    = '0;
    repeat (3) tick;
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_clkout", 32'(clkout), 32'h0);
    check("rst_clkoutb", 32'(clkoutb), 32'h0);
    check("rst_drdy", 32'(bus.DRDY), 32'h0);
    check("rst_do", 32'(bus.DO), 32'h0);

    rstn = 1'b1;
    wait_lock(n);
    check("lock_after_reset", 32'(n), 32'(LC + 1));
    check("div2_e0_clkout", 32'(clkout), 32'h7f);
    check("div2_e0_clkoutb", 32'(clkoutb), 32'h00);
    tick;
    check("div2_e1_clkout", 32'(clkout), 32'h00);
    check("div2_e1_clkoutb", 32'(clkoutb), 32'h7f);
    tick;
    check("div2_e2_clkout", 32'(clkout), 32'h7f);

    drp(1'b0, 7'd0, 16'h0, rdo, rdy, lk, rdy2);
    check("rd0_default", 32'(rdo), 32'h0101);
    check("rd0_drdy", 32'(rdy), 32'h1);
    check("rd0_drdy_one_cycle", 32'(rdy2), 32'h0);
    check("rd0_keeps_lock", 32'(lk), 32'h1);
    drp(1'b0, 7'd1, 16'h0, rdo, rdy, lk, rdy2);
    check("rd1_default", 32'(rdo), 32'h0100);

    drp(1'b1, 7'd0, 16'h0203, rdo, rdy, lk, rdy2);
    check("wr0_prewrite_do", 32'(rdo), 32'h0101);
    check("wr0_drdy", 32'(rdy), 32'h1);
    check("wr0_unlock", 32'(lk), 32'h0);
    wait_lock(n);
    check("wr0_relock", 32'(n), 32'(LC - 1));
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pat[k]  = clkout[0];
      expv[k] = ((k % 5) < 2);
      if (clkout[1] !== ((k % 2) == 0)) bad = 1'b1;
      tick;
    end
    check("ch0_h2_l3_pattern", 32'(pat), 32'(expv));
    check("ch1_unchanged_div2", 32'(bad), 32'h0);
    drp(1'b0, 7'd0, 16'h0, rdo, rdy, lk, rdy2);
    check("rd0_after_wr", 32'(rdo), 32'h0203);

    drp(1'b1, 7'd3, 16'h0104, rdo, rdy, lk, rdy2);
    wait_lock(n);
    for (int k = 0; k < 10; k++) begin
      pat[k]  = clkout[1];
      expv[k] = (k < 4) ? 1'b0 : (((k - 4) % 2) == 0);
      tick;
    end
    check("ch1_phase4_pattern", 32'(pat), 32'(expv));

    drp(1'b1, 7'd3, 16'h0000, rdo, rdy, lk, rdy2);
    check("wr3_prewrite_do", 32'(rdo), 32'h0104);
    wait_lock(n);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (clkout[1] !== 1'b0 || clkoutb[1] !== 1'b1) bad = 1'b1;
      tick;
    end
    check("ch1_disabled_levels", 32'(bad), 32'h0);
    drp(1'b0, 7'd3, 16'h0, rdo, rdy, lk, rdy2);
    check("rd3_disabled", 32'(rdo), 32'h0000);

    drp(1'b1, 7'd4, 16'h0000, rdo, rdy, lk, rdy2);
    drp(1'b0, 7'd4, 16'h0, rdo, rdy, lk, rdy2);
    check("rd4_zero_fields", 32'(rdo), 32'h0000);
    wait_lock(n);
    hi = 0;
    while (clkout[2] === 1'b1 && hi < 1000) begin
      hi++;
      tick;
    end
    lo = 0;
    while (clkout[2] === 1'b0 && lo < 1000) begin
      lo++;
      tick;
    end
    check("ch2_high_256", 32'(hi), 32'd256);
    check("ch2_low_256", 32'(lo), 32'd256);

    drp(1'b0, 7'd14, 16'h0, rdo, rdy, lk, rdy2);
    check("rd14_zero", 32'(rdo), 32'h0000);
    check("rd14_drdy", 32'(rdy), 32'h1);
    drp(1'b1, 7'd14, 16'hffff, rdo, rdy, lk, rdy2);
    check("wr14_unlock", 32'(lk), 32'h0);
    bad = 1'b0;
    for (int w = 0; w < 15; w++) begin
      for (int k = 0; k < 7; k++) begin
        tick;
        if (locked !== 1'b0) bad = 1'b1;
      end
      drp(1'b1, 7'd14, 16'h1234, rdo, rdy, lk, rdy2);
      if (lk !== 1'b0 || locked !== 1'b0) bad = 1'b1;
    end
    check("writes_every_10_hold_unlock", 32'(bad), 32'h0);
    wait_lock(n);
    check("relock_after_writes", 32'(n), 32'(LC - 1));

    pwrdwn = 1'b1;
    tick;
    check("pwrdwn_locked", 32'(locked), 32'h0);
    check("pwrdwn_clkout", 32'(clkout), 32'h0);
    check("pwrdwn_clkoutb", 32'(clkoutb), 32'h0);
    drp(1'b0, 7'd0, 16'h0, rdo, rdy, lk, rdy2);
    check("pwrdwn_drp_read", 32'(rdo), 32'h0203);
    check("pwrdwn_drp_drdy", 32'(rdy), 32'h1);
    pwrdwn = 1'b0;
    wait_lock(n);
    check("pwrdwn_relock", 32'(n), 32'(LC + 1));

    tick;
    tick;
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_locked", 32'(locked), 32'h0);
    check("async_rst_clkout", 32'(clkout), 32'h0);
    check("async_rst_clkoutb", 32'(clkoutb), 32'h0);
    tick;
    rstn = 1'b1;
    drp(1'b0, 7'd0, 16'h0, rdo, rdy, lk, rdy2);
    check("rst_restores_ch0", 32'(rdo), 32'h0101);
    drp(1'b0, 7'd3, 16'h0, rdo, rdy, lk, rdy2);
    check("rst_restores_ch1_phase", 32'(rdo), 32'h0100);
    drp(1'b0, 7'd4, 16'h0, rdo, rdy, lk, rdy2);
    check("rst_restores_ch2", 32'(rdo), 32'h0101);
    wait_lock(n);
    check("rst_relock", 32'(n), 32'(LC + 1 - 9));
    check("rst_relock_div2", 32'(clkout), 32'h7f);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
